control_unit: RTL and testbench

Fetch/decode/execute sequencer for the 8-bit CPU, and the block that drives the ALU: it fetches 24-bit instructions, reads a 4-entry register file, presents `alu_op`/`operand_a`/`operand_b` to the ALU, and then commits the result. Commit means one of three things: write back to the register file, take a conditional branch on the compare result, or latch the overflow flags. It sits between instruction memory and the ALU in the CPU top level.

---
 rtl/control_unit_pkg.sv | 63 ++++++
 rtl/control_unit_register_file.sv | 34 +++
 rtl/control_unit.sv | 153 +++++++++++++++
 tb/tb_control_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit CPU control unit.
// ALU codes, instruction classes, field positions, FSM states.
package control_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [3:0] ALU_PUR = 4'h0;
  localparam logic [3:0] ALU_SAD = 4'h1;
  localparam logic [3:0] ALU_SSB = 4'h2;
  localparam logic [3:0] ALU_SHL = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4;
  localparam logic [3:0] ALU_AND = 4'h5;
  localparam logic [3:0] ALU_OR  = 4'h6;
  localparam logic [3:0] ALU_XOR = 4'h7;
  localparam logic [3:0] ALU_EQ  = 4'h8;
  localparam logic [3:0] ALU_LT  = 4'h9;

  localparam int F_CLS_HI = 23;
  localparam int F_CLS_LO = 22;
  localparam int F_IMMSEL = 21;
  localparam int F_OP_HI  = 20;
  localparam int F_OP_LO  = 17;
  localparam int F_RD_HI  = 16;
  localparam int F_RD_LO  = 15;
  localparam int F_RA_HI  = 14;
  localparam int F_RA_LO  = 13;
  localparam int F_RB_HI  = 12;
  localparam int F_RB_LO  = 11;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_BR  = 2'b01,
    CLS_NOP = 2'b10,
    CLS_HLT = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  typedef struct packed {
    cls_e       cls;
    logic       imm_sel;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] rsvd;
    logic [7:0] imm;
  } instr_t;

  function automatic logic [7:0] pc_next(logic [7:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/control_unit_register_file.sv
// 4x8 register file: two operand read ports, debug read port.
// Ports: ra/rb/dbg read addr+data, we/wr_addr/wr_data sync write.
module register_file (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  input  logic [1:0] dbg_sel,
  input  logic       we,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] dbg_data
);

  logic [3:0][7:0] regs_q;
  logic [3:0][7:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the external ALU.
// Ports: instr fetch bus, ALU operands/result/flags, retire, halt, debug.
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_req,
  output logic [7:0]  instr_addr,
  input  logic        instr_valid,
  input  logic [23:0] instr_data,
  output logic [3:0]  alu_op,
  output logic [7:0]  operand_a,
  output logic [7:0]  operand_b,
  input  logic [7:0]  alu_result,
  input  logic        shift_overflow,
  input  logic        arithmetic_overflow,
  output logic        flag_shift,
  output logic        flag_arith,
  output logic        instr_retired,
  output logic        halted,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  state_e     state_q, state_d;
  instr_t     ir_q, ir_d;
  logic [7:0] pc_q, pc_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic       fs_q, fs_d;
  logic       fa_q, fa_d;
  logic       halted_q, halted_d;
  logic       rf_we;
  logic       retired;
  logic [7:0] ra_data;
  logic [7:0] rb_data;
  logic       is_alu, is_br, is_hlt;

  // Reserved instruction bits are carried in IR but never decoded.
  logic unused_rsvd;
  assign unused_rsvd = ^ir_q.rsvd;

  assign is_alu = (ir_q.cls == CLS_ALU);
  assign is_br  = (ir_q.cls == CLS_BR);
  assign is_hlt = (ir_q.cls == CLS_HLT);

  register_file u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra_addr  (ir_q.ra),
    .rb_addr  (ir_q.rb),
    .dbg_sel  (dbg_sel),
    .we       (rf_we),
    .wr_addr  (ir_q.rd),
    .wr_data  (alu_result),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    alu_op_d = alu_op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    fs_d     = fs_q;
    fa_d     = fa_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    retired  = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_t'(instr_data);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opa_d    = ra_data;
        // Branch compares two registers; imm is its target.
        opb_d    = (ir_q.imm_sel && !is_br) ? ir_q.imm : rb_data;
        alu_op_d = ir_q.op;
        if (is_hlt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          retired  = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        retired = 1'b1;
        state_d = ST_FETCH;
        pc_d    = pc_next(pc_q);
        unique case (1'b1)
          is_alu: begin
            rf_we = 1'b1;
            fs_d  = shift_overflow;
            fa_d  = arithmetic_overflow;
          end
          is_br: begin
            if (alu_result[0] == TRUE) pc_d = ir_q.imm;
          end
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      ir_q     <= '0;
      pc_q     <= RESET_PC;
      alu_op_q <= 4'd0;
      opa_q    <= 8'd0;
      opb_q    <= 8'd0;
      fs_q     <= 1'b0;
      fa_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      alu_op_q <= alu_op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      fs_q     <= fs_d;
      fa_q     <= fa_d;
      halted_q <= halted_d;
    end
  end

  assign instr_req     = (state_q == ST_FETCH);
  assign instr_addr    = pc_q;
  assign alu_op        = alu_op_q;
  assign operand_a     = opa_q;
  assign operand_b     = opb_q;
  assign flag_shift    = fs_q;
  assign flag_arith    = fa_q;
  assign instr_retired = retired;
  assign halted        = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit with an environment ALU.
// Directed table, random program vs reference model, halt/reset.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid = 1'b0;
  logic [23:0] instr_data = '0;
  logic [3:0]  alu_op;
  logic [7:0]  operand_a, operand_b;
  logic [7:0]  alu_res;
  logic        sh_ovf, ar_ovf;
  logic        flag_shift, flag_arith;
  logic        instr_retired, halted;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;
  int retire_cnt = 0;
  int exp_retires = 0;

  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic       m_fs, m_fa;

  control_unit #(.RESET_PC(8'h00)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_req           (instr_req),
    .instr_addr          (instr_addr),
    .instr_valid         (instr_valid),
    .instr_data          (instr_data),
    .alu_op              (alu_op),
    .operand_a           (operand_a),
    .operand_b           (operand_b),
    .alu_result          (alu_res),
    .shift_overflow      (sh_ovf),
    .arithmetic_overflow (ar_ovf),
    .flag_shift          (flag_shift),
    .flag_arith          (flag_arith),
    .instr_retired       (instr_retired),
    .halted              (halted),
    .dbg_sel             (dbg_sel),
    .dbg_data            (dbg_data)
  );

  always #10 clk = ~clk;

  // Environment ALU: returns {shift_ovf, arith_ovf, result}.
  function automatic logic [9:0] alu_ref(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0]  r = a;
    logic        so = 1'b0;
    logic        ao = 1'b0;
    logic [15:0] w;
    logic [7:0]  mask;
    case (op)
      ALU_PUR: r = b;
      ALU_SAD: begin
        r  = a + b;
        ao = (a[7] == b[7]) && (r[7] != a[7]);
      end
      ALU_SSB: begin
        r  = a - b;
        ao = (a[7] != b[7]) && (r[7] != a[7]);
      end
      ALU_SHL: begin
        w  = {8'd0, a} << b[2:0];
        r  = w[7:0];
        so = |w[15:8];
      end
      ALU_SHR: begin
        mask = (8'd1 << b[2:0]) - 8'd1;
        r    = a >> b[2:0];
        so   = |(a & mask);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_EQ:  r = {7'd0, a == b};
      ALU_LT:  r = {7'd0, $signed(a) < $signed(b)};
      default: r = a;
    endcase
    return {so, ao, r};
  endfunction

  always_comb {sh_ovf, ar_ovf, alu_res} = alu_ref(alu_op, operand_a, operand_b);

  always @(posedge clk) if (instr_retired) retire_cnt <= retire_cnt + 1;

  function automatic logic [23:0] mk(logic [1:0] c, logic isel, logic [3:0] op,
                                     logic [1:0] rd, logic [1:0] ra, logic [1:0] rb,
                                     logic [7:0] imm);
    return {c, isel, op, rd, ra, rb, 3'b000, imm};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00;
    m_fs = 1'b0;
    m_fa = 1'b0;
  endtask

  task automatic chk_regs(string name);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk(name, dbg_data, m_reg[i]);
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", instr_req, 0);
    chk("rst_addr", instr_addr, 8'h00);
    chk("rst_aluop", alu_op, 0);
    chk("rst_opa", operand_a, 0);
    chk("rst_opb", operand_b, 0);
    chk("rst_flags", {flag_shift, flag_arith}, 0);
    chk("rst_retired", instr_retired, 0);
    chk("rst_halted", halted, 0);
    chk_regs("rst_reg");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_req_low", instr_req, 0);
    @(negedge clk);
    chk("rel_req_high", instr_req, 1);
    chk("rel_addr", instr_addr, 8'h00);
  endtask

  // Runs one non-HALT instruction; starts and ends in a FETCH cycle.
  task automatic run_instr(logic [23:0] ins, int waits);
    int guard = 0;
    logic [1:0] c   = ins[23:22];
    logic       isl = ins[21];
    logic [3:0] op  = ins[20:17];
    logic [1:0] rd  = ins[16:15];
    logic [1:0] ra  = ins[14:13];
    logic [1:0] rb  = ins[12:11];
    logic [7:0] imm = ins[7:0];
    logic [7:0] a, b;
    logic [9:0] res;
    while (instr_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("fetch_timeout", instr_req, 1);
    if (instr_req !== 1'b1) return;
    chk("fetch_addr", instr_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      instr_data  = 24'($urandom);
      @(negedge clk);
      chk("wait_req", instr_req, 1);
      chk("wait_addr", instr_addr, m_pc);
      chk("wait_noretire", instr_retired, 0);
    end
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge clk);
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 24'($urandom);
    chk("dec_req", instr_req, 0);
    chk("dec_noretire", instr_retired, 0);
    @(negedge clk);
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 24'($urandom);
    a = m_reg[ra];
    b = (c == 2'b01 || !isl) ? m_reg[rb] : imm;
    chk("ex_retire", instr_retired, 1);
    chk("ex_aluop", alu_op, op);
    chk("ex_opa", operand_a, a);
    chk("ex_opb", operand_b, b);
    res = alu_ref(op, a, b);
    case (c)
      2'b00: begin
        m_reg[rd] = res[7:0];
        m_fs = res[9];
        m_fa = res[8];
        m_pc = m_pc + 8'd1;
      end
      2'b01: m_pc = res[0] ? imm : m_pc + 8'd1;
      default: m_pc = m_pc + 8'd1;
    endcase
    exp_retires++;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("post_noretire", instr_retired, 0);
    chk("post_req", instr_req, 1);
    chk("post_pc", instr_addr, m_pc);
    chk("post_flags", {flag_shift, flag_arith}, {m_fs, m_fa});
    chk_regs("post_reg");
  endtask

  typedef struct {
    logic [23:0] ins;
    int          waits;
    logic [7:0]  exp_pc;
    logic [1:0]  rsel;
    logic [7:0]  rval;
    logic        fs;
    logic        fa;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{mk(2'b01, 1, ALU_EQ,  0, 0, 1, 8'h40), 0, 8'h40, 1, 8'h00, 0, 0};
    vt[1] = '{mk(2'b00, 1, ALU_PUR, 1, 0, 0, 8'h05), 0, 8'h41, 1, 8'h05, 0, 0};
    vt[2] = '{mk(2'b01, 0, ALU_EQ,  0, 0, 1, 8'h10), 1, 8'h42, 1, 8'h05, 0, 0};
    vt[3] = '{mk(2'b00, 1, ALU_PUR, 1, 0, 0, 8'h7F), 0, 8'h43, 1, 8'h7F, 0, 0};
    vt[4] = '{mk(2'b00, 1, ALU_SAD, 1, 1, 0, 8'h01), 0, 8'h44, 1, 8'h80, 0, 1};
    vt[5] = '{mk(2'b00, 1, ALU_PUR, 2, 0, 0, 8'h81), 2, 8'h45, 2, 8'h81, 0, 0};
    vt[6] = '{mk(2'b00, 1, ALU_SHL, 3, 2, 0, 8'h01), 0, 8'h46, 3, 8'h02, 1, 0};
    vt[7] = '{mk(2'b10, 0, ALU_PUR, 0, 0, 0, 8'h00), 5, 8'h47, 3, 8'h02, 1, 0};
    vt[8] = '{mk(2'b01, 0, ALU_EQ,  0, 0, 0, 8'hFF), 0, 8'hFF, 0, 8'h00, 1, 0};
    vt[9] = '{mk(2'b10, 0, ALU_PUR, 0, 0, 0, 8'h00), 0, 8'h00, 3, 8'h02, 1, 0};

    do_reset();

    foreach (vt[i]) begin
      run_instr(vt[i].ins, vt[i].waits);
      chk("tbl_pc", instr_addr, vt[i].exp_pc);
      dbg_sel = vt[i].rsel;
      #1;
      chk("tbl_reg", dbg_data, vt[i].rval);
      chk("tbl_flags", {flag_shift, flag_arith}, {vt[i].fs, vt[i].fa});
    end

    for (int n = 0; n < 60; n++) begin
      logic [23:0] ins;
      ins = 24'($urandom);
      ins[23:22] = 2'($urandom_range(0, 2));
      ins[20:17] = 4'($urandom_range(0, 9));
      run_instr(ins, $urandom_range(0, 3));
    end

    // HALT: retire pulse in DECODE, then absorbing.
    begin
      logic [7:0] hpc;
      hpc = m_pc;
      chk("halt_fetch_addr", instr_addr, hpc);
      instr_valid = 1'b1;
      instr_data  = mk(2'b11, 0, ALU_PUR, 0, 0, 0, 8'h00);
      @(negedge clk);
      chk("halt_retire", instr_retired, 1);
      chk("halt_dec_req", instr_req, 0);
      exp_retires++;
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_noretire", instr_retired, 0);
      for (int i = 0; i < 8; i++) begin
        instr_valid = 1'b1;
        instr_data  = 24'($urandom);
        @(negedge clk);
        chk("halt_req", instr_req, 0);
        chk("halt_hold", halted, 1);
        chk("halt_pc", instr_addr, hpc);
        chk("halt_idle", instr_retired, 0);
      end
    end

    @(negedge clk);
    chk("retire_count", retire_cnt, exp_retires);

    do_reset();
    chk("restart_halted", halted, 0);
    run_instr(mk(2'b00, 1, ALU_PUR, 0, 0, 0, 8'hA5), 0);
    run_instr(mk(2'b00, 0, ALU_SAD, 2, 0, 0, 8'h00), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
